// File: rtl/inv_sub_bytes_iter.sv
// inv_sub_bytes_iter: iterative AES InvSubBytes engine, LANES bytes substituted per clock
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data[127:0] accept a state;
//        out_valid/out_ready/out_data[127:0] return it, byte k = InvSbox(in byte k).
// Define INV_SUB_BYTES_FWD_EN to add the mode input (captured at accept, 1 = forward S-box).
module inv_sbox (
  input  logic [7:0] S_in,
  output logic [7:0] S_out
);
  localparam logic [2047:0] T = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
  // entry 0 sits in the top byte, so entry x starts at bit 8*(255-x) = {~x,000}
  assign S_out = T[{~S_in, 3'b000} +: 8];
endmodule

`ifdef INV_SUB_BYTES_FWD_EN
module sbox (
  input  logic [7:0] S_in,
  output logic [7:0] S_out
);
  localparam logic [2047:0] T = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  assign S_out = T[{~S_in, 3'b000} +: 8];
endmodule
`endif

module inv_sub_bytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
`ifdef INV_SUB_BYTES_FWD_EN
  ,
  input  logic         mode
`endif
);
  localparam int BEATS = 16 / LANES;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [127:0] r_data, w_data;
  logic [7:0] w_sin [LANES];
  logic [7:0] w_sout [LANES];
  logic w_last, w_accept;
`ifdef INV_SUB_BYTES_FWD_EN
  logic r_mode;
`endif
  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad
    $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end
  assign w_last = r_cnt == CW'(BEATS - 1);
  assign w_accept = r_state == IDLE && in_valid;
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [7:0] w_inv;
    assign w_sin[j] = r_data[8 * (int'(r_cnt) * LANES + j) +: 8];
    inv_sbox u_inv (.S_in(w_sin[j]), .S_out(w_inv));
`ifdef INV_SUB_BYTES_FWD_EN
    logic [7:0] w_fwd;
    sbox u_fwd (.S_in(w_sin[j]), .S_out(w_fwd));
    assign w_sout[j] = r_mode ? w_fwd : w_inv;
`else
    assign w_sout[j] = w_inv;
`endif
  end
  always_comb begin
    w_data = r_data;
    for (int j = 0; j < LANES; j++) w_data[8 * (int'(r_cnt) * LANES + j) +: 8] = w_sout[j];
  end
  always_comb begin
    w_next = w_accept ? BUSY :
             (r_state == BUSY && w_last) ? DONE :
             (r_state == DONE && out_ready) ? IDLE : r_state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
      r_mode  <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_data <= in_data;
        r_cnt  <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
        r_mode <= mode;
`endif
      end else if (r_state == BUSY) begin
        r_data <= w_data;
        // wrap on the last beat so the lane index never leaves the 16-byte state
        r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
      end
    end
  end
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign out_data  = out_valid ? r_data : '0;
endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// tb_inv_sub_bytes_iter: self-checking bench for inv_sub_bytes_iter against a GF(2^8) S-box model
module tb_inv_sub_bytes_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic mode = 1'b0;
  logic [127:0] in_data = '0;
  logic in_ready, out_valid;
  logic [127:0] out_data;
  logic [4:0] rt_iv = '0;
  logic [4:0] rt_or = '0;
  logic [4:0] rt_ir, rt_ov;
  logic [127:0] rt_id [5];
  logic [127:0] rt_od [5];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [127:0] exp_q [$];
  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inv_sub_bytes_iter #(.LANES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef INV_SUB_BYTES_FWD_EN
    , .mode(mode)
`endif
  );

  for (genvar g = 0; g < 5; g++) begin : g_rt
    inv_sub_bytes_iter #(.LANES(1 << g)) u_rt (
      .clk(clk), .rst(rst), .in_valid(rt_iv[g]), .in_ready(rt_ir[g]), .in_data(rt_id[g]),
      .out_valid(rt_ov[g]), .out_ready(rt_or[g]), .out_data(rt_od[g])
`ifdef INV_SUB_BYTES_FWD_EN
      , .mode(1'b0)
`endif
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // forward S-box = affine(x^254); inverse table is its inverse permutation
  task automatic init_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] r = 8'h01;
      logic [7:0] s;
      for (int i = 0; i < 254; i++) r = gmul(r, 8'(x));
      s = r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
      fwd_t[x] = s;
      inv_t[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] sub_state(input logic [127:0] s, input bit f);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = f ? fwd_t[s[8*k +: 8]] : inv_t[s[8*k +: 8]];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [127:0] d, input logic [127:0] e, input logic md);
    int n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    in_valid = 1'b1;
    in_data = d;
    mode = md;
    exp_q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin tick(); lat++; end
  endtask

  task automatic test_reset();
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_zero();
    int lat;
    put('0, sub_state('0, 1'b0), 1'b0);
    wait_out(lat);
    checks++; if (lat !== 5) begin failures++; $display("FAIL zero_latency got=%0d exp=5", lat); end
    checks++; if (out_data !== {16{8'h52}}) begin failures++; $display("FAIL zero_const got=%h exp=%h", out_data, {16{8'h52}}); end
    begin
      logic [127:0] e = exp_q.pop_front();
      checks++; if (out_data !== e) begin failures++; $display("FAIL zero_model got=%h exp=%h", out_data, e); end
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL zero_release got=%b exp=0", out_valid); end
  endtask

  task automatic test_pattern();
    int lat;
    logic [127:0] d = {4{8'hff, 8'hed, 8'h7c, 8'h63}};
    logic [127:0] e;
    put(d, sub_state(d, 1'b0), 1'b0);
    wait_out(lat);
    e = exp_q.pop_front();
    checks++; if (out_data !== {4{8'h7d, 8'h53, 8'h01, 8'h00}}) begin failures++; $display("FAIL pattern_const got=%h exp=%h", out_data, {4{8'h7d, 8'h53, 8'h01, 8'h00}}); end
    checks++; if (out_data !== e) begin failures++; $display("FAIL pattern_model got=%h exp=%h", out_data, e); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat, prev, stamp;
    prev = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
      logic [127:0] e;
      put(d, sub_state(d, 1'b0), 1'b0);
      wait_out(lat);
      stamp = cyc;
      e = exp_q.pop_front();
      checks++; if (out_data !== e) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, out_data, e); end
      if (i > 0) begin
        checks++; if (stamp - prev !== 6) begin failures++; $display("FAIL b2b_period[%0d] got=%0d exp=6", i, stamp - prev); end
      end
      prev = stamp;
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] held, e;
    put(d, sub_state(d, 1'b0), 1'b0);
    wait_out(lat);
    held = out_data;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 3);
      in_data = ~d;
      tick();
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== held) begin
        failures++; $display("FAIL bp_hold[%0d] got=%b%b/%h exp=10/%h", i, out_valid, in_ready, out_data, held);
      end
    end
    in_valid = 1'b0;
    e = exp_q.pop_front();
    checks++; if (out_data !== e) begin failures++; $display("FAIL bp_data got=%h exp=%h", out_data, e); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_no_extra[%0d] got=%b%b exp=01", i, out_valid, in_ready); end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] d2 = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] e;
    put(d, sub_state(d, 1'b0), 1'b0);
    tick(); tick();
    rst = 1'b1;
    #1;
    void'(exp_q.pop_back());
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL mid_reset got=%b%b exp=01", out_valid, in_ready); end
    tick();
    rst = 1'b0;
    tick();
    put(d2, sub_state(d2, 1'b0), 1'b0);
    wait_out(lat);
    e = exp_q.pop_front();
    checks++; if (lat !== 5) begin failures++; $display("FAIL mid_reset_latency got=%0d exp=5", lat); end
    checks++; if (out_data !== e) begin failures++; $display("FAIL mid_reset_data got=%h exp=%h", out_data, e); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_round_trip();
    logic [127:0] orig = 128'h00112233445566778899aabbccddeeff;
    logic [127:0] d = sub_state(orig, 1'b1);
    for (int g = 0; g < 5; g++) begin
      int lat = 1;
      logic [127:0] e;
      rt_id[g] = d;
      rt_iv[g] = 1'b1;
      exp_q.push_back(orig);
      tick();
      rt_iv[g] = 1'b0;
      while (!rt_ov[g] && lat < 40) begin tick(); lat++; end
      e = exp_q.pop_front();
      checks++; if (lat !== (16 >> g) + 1) begin failures++; $display("FAIL rt_latency[L=%0d] got=%0d exp=%0d", 1 << g, lat, (16 >> g) + 1); end
      checks++; if (rt_od[g] !== e) begin failures++; $display("FAIL rt_data[L=%0d] got=%h exp=%h", 1 << g, rt_od[g], e); end
      rt_or[g] = 1'b1; tick(); rt_or[g] = 1'b0;
      checks++; if (rt_ov[g] !== 1'b0 || rt_ir[g] !== 1'b1) begin failures++; $display("FAIL rt_release[L=%0d] got=%b%b exp=01", 1 << g, rt_ov[g], rt_ir[g]); end
    end
  endtask

`ifdef INV_SUB_BYTES_FWD_EN
  task automatic test_fwd();
    int lat;
    logic [127:0] e;
    put('0, sub_state('0, 1'b1), 1'b1);
    mode = 1'b0;
    wait_out(lat);
    e = exp_q.pop_front();
    checks++; if (out_data !== {16{8'h63}}) begin failures++; $display("FAIL fwd_const got=%h exp=%h", out_data, {16{8'h63}}); end
    checks++; if (out_data !== e) begin failures++; $display("FAIL fwd_model got=%h exp=%h", out_data, e); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL fwd_latency got=%0d exp=5", lat); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    put('0, sub_state('0, 1'b0), 1'b0);
    wait_out(lat);
    e = exp_q.pop_front();
    checks++; if (out_data !== {16{8'h52}} || out_data !== e) begin failures++; $display("FAIL fwd_mode0 got=%h exp=%h", out_data, e); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    for (int g = 0; g < 5; g++) rt_id[g] = '0;
    init_tables();
    test_reset();
    test_zero();
    test_pattern();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_round_trip();
`ifdef INV_SUB_BYTES_FWD_EN
    test_fwd();
`endif
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
